pmem_responder: RTL

//  Physical-memory side of the pmem handshake. Serves line reads and line writes

---
 rtl/pmem_responder_pkg.sv | 17 +
 rtl/pmem_line_array.sv | 25 ++
 rtl/pmem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem responder: cache line type, offset width and the FSM
// state encoding, which benches decode.
package pmem_responder_pkg;

   localparam int unsigned PMEM_OFFSET_BITS = 4;

   typedef logic [127:0] lc3b_c_line;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP,
      S_RECOVER
   } pmem_state_e;

endpackage

// File: rtl/pmem_line_array.sv
// Line store: synchronous write port and registered read port. The storage has no
// reset, so its contents are undefined until written.
module pmem_line_array
   import pmem_responder_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] windex,
   input  lc3b_c_line            wline,
   input  logic [INDEX_BITS-1:0] rindex,
   output lc3b_c_line            rline
);

   lc3b_c_line mem [2**INDEX_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[windex] <= wline;
      end
      rline <= mem[rindex];
   end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory side of the pmem handshake: fixed-latency line reads and writes,
// with reads pre-empting an in-flight write, which is then dropped uncommitted.
module pmem_responder
   import pmem_responder_pkg::*;
#(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pmem_address,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  lc3b_c_line  pmem_wdata,
   output logic        pmem_resp,
   output lc3b_c_line  pmem_rdata
);

   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   pmem_state_e           state_q, state_d;
   logic [3:0]            count_q, count_d;
   logic [INDEX_BITS-1:0] index_q, index_d;
   lc3b_c_line            wdata_q, wdata_d;
   logic                  is_write_q, is_write_d;
   lc3b_c_line            rdata_q;
   lc3b_c_line            arr_line;
   logic                  mem_we;
   logic [INDEX_BITS-1:0] addr_index;
   logic                  addr_unused;

   assign addr_index  = pmem_address[INDEX_BITS+PMEM_OFFSET_BITS-1:PMEM_OFFSET_BITS];
   assign addr_unused = ^{pmem_address[15:INDEX_BITS+PMEM_OFFSET_BITS],
                          pmem_address[PMEM_OFFSET_BITS-1:0]};

   pmem_line_array #(
      .INDEX_BITS (INDEX_BITS)
   ) u_line_array (
      .clk    (clk),
      .we     (mem_we),
      .windex (index_q),
      .wline  (wdata_q),
      .rindex (index_q),
      .rline  (arr_line)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      index_d    = index_q;
      wdata_d    = wdata_q;
      is_write_d = is_write_q;
      pmem_resp  = 1'b0;
      mem_we     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pmem_read) begin
               state_d    = S_READ;
               index_d    = addr_index;
               count_d    = COUNT_LOAD;
               is_write_d = 1'b0;
            end else if (pmem_write) begin
               state_d    = S_WRITE;
               index_d    = addr_index;
               wdata_d    = pmem_wdata;
               count_d    = COUNT_LOAD;
               is_write_d = 1'b1;
            end
         end
         S_READ: begin
            if (!pmem_read) begin
               state_d = S_IDLE;
            end else if (addr_index != index_q) begin
               index_d = addr_index;
               count_d = COUNT_LOAD;
            end else if (count_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         S_WRITE: begin
            // A read pre-empts the write; the requester re-issues the write later.
            if (pmem_read) begin
               state_d    = S_READ;
               index_d    = addr_index;
               count_d    = COUNT_LOAD;
               is_write_d = 1'b0;
            end else if (!pmem_write) begin
               state_d = S_IDLE;
            end else if (addr_index != index_q) begin
               index_d = addr_index;
               wdata_d = pmem_wdata;
               count_d = COUNT_LOAD;
            end else if (count_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         S_RESP: begin
            pmem_resp = 1'b1;
            mem_we    = is_write_q;
            state_d   = S_RECOVER;
         end
         S_RECOVER: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The array's registered read lands on S_RESP entry; rdata_q holds it afterwards.
   assign pmem_rdata = (state_q == S_RESP && !is_write_q) ? arr_line : rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= 4'd0;
         index_q    <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         index_q    <= index_d;
         wdata_q    <= wdata_d;
         is_write_q <= is_write_d;
         if (state_q == S_RESP && !is_write_q) begin
            rdata_q <= arr_line;
         end
      end
   end

endmodule
